// File: rtl/leve1_csr_exec_pkg.sv
// Shared types, funct3 encodings and the legality rule for the Zicsr executor.
// Also provides the CSR command / privilege defines if defs.vh has not been seen.
`ifndef CSR_NONE
`define CSR_NONE  2'd0
`define CSR_WRITE 2'd1
`define CSR_SET   2'd2
`define CSR_CLEAR 2'd3
`endif
`ifndef MODE_U
`define MODE_U 2'd0
`define MODE_S 2'd1
`define MODE_M 2'd3
`endif

package leve1_csr_exec_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // Passing mode = M effectively disables the privilege test (csr[9:8] <= 3 always).
    function automatic logic is_illegal(input logic [2:0]  funct3,
                                        input logic [11:0] csr,
                                        input logic [4:0]  rs1,
                                        input logic [1:0]  mode);
        logic bad_funct3;
        logic do_write;
        bad_funct3 = (funct3[1:0] == 2'b00);
        do_write   = (funct3 == F3_RW) || (funct3 == F3_RWI) || (rs1 != 5'd0);
        return bad_funct3 || (do_write && (csr[11:10] == 2'b11)) || (csr[9:8] > mode);
    endfunction

endpackage

// File: rtl/leve1_csr_decode.sv
// Combinational decode of a Zicsr request: command, operand select, write enable, legality.
module leve1_csr_decode
    import leve1_csr_exec_pkg::*;
#(
    parameter bit MODE_CHECK = 1'b1
) (
    input  logic [2:0]  funct3,
    input  logic [11:0] csr,
    input  logic [4:0]  rs1,
    input  logic [1:0]  mode,
    output logic [1:0]  cmd,
    output logic        use_imm,
    output logic        do_write,
    output logic        illegal
);

    always_comb begin
        cmd = `CSR_NONE;
        case (funct3)
            F3_RW, F3_RWI: cmd = `CSR_WRITE;
            F3_RS, F3_RSI: cmd = `CSR_SET;
            F3_RC, F3_RCI: cmd = `CSR_CLEAR;
            default:       cmd = `CSR_NONE;
        endcase
        use_imm  = funct3[2];
        do_write = (funct3 == F3_RW) || (funct3 == F3_RWI) || (rs1 != 5'd0);
        illegal  = is_illegal(funct3, csr, rs1, MODE_CHECK ? mode : `MODE_M);
    end

endmodule

// File: rtl/leve1_csr_exec.sv
// Zicsr executor: read old CSR value, issue write/set/clear, return old value for rd.
// Build option LEVE1_CSR_EXEC_FASTPATH_EN issues the write command alongside the read.
module leve1_csr_exec
    import leve1_csr_exec_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter bit MODE_CHECK = 1'b1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_FUNCT3,
    input  logic [11:0]     REQ_CSR,
    input  logic [4:0]      REQ_RS1,
    input  logic [XLEN-1:0] REQ_RS1_VAL,
    input  logic [4:0]      REQ_RD,
    input  logic [1:0]      REQ_MODE,
    output logic [11:0]     CSR_RA,
    input  logic [XLEN-1:0] CSR_RD,
    output logic [1:0]      CSR_WCMD,
    output logic [11:0]     CSR_WA,
    output logic [XLEN-1:0] CSR_WD,
    output logic            RESP_VALID,
    input  logic            RESP_READY,
    output logic [4:0]      RESP_RD,
    output logic            RESP_WE,
    output logic [XLEN-1:0] RESP_DATA,
    output logic            RESP_ILLEGAL,
    output logic            RETIRE
);

`ifdef LEVE1_CSR_EXEC_FASTPATH_EN
    localparam bit FASTPATH = 1'b1;
`else
    localparam bit FASTPATH = 1'b0;
`endif

    state_t          state;
    logic [11:0]     csr_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] old_q;
    logic [1:0]      cmd_q;
    logic            do_write_q;

    logic [1:0]      dec_cmd;
    logic            dec_use_imm;
    logic            dec_do_write;
    logic            dec_illegal;
    logic [XLEN-1:0] operand;
    logic            accept;

    leve1_csr_decode #(.MODE_CHECK(MODE_CHECK)) u_decode (
        .funct3   (REQ_FUNCT3),
        .csr      (REQ_CSR),
        .rs1      (REQ_RS1),
        .mode     (REQ_MODE),
        .cmd      (dec_cmd),
        .use_imm  (dec_use_imm),
        .do_write (dec_do_write),
        .illegal  (dec_illegal)
    );

    assign operand   = dec_use_imm ? {{(XLEN-5){1'b0}}, REQ_RS1} : REQ_RS1_VAL;
    assign REQ_READY = (state == IDLE) && !RST;
    assign accept    = REQ_VALID && REQ_READY;
    assign RETIRE    = RESP_VALID && RESP_READY && !RESP_ILLEGAL;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            csr_q        <= '0;
            rd_q         <= '0;
            operand_q    <= '0;
            old_q        <= '0;
            cmd_q        <= `CSR_NONE;
            do_write_q   <= 1'b0;
            CSR_RA       <= '0;
            CSR_WCMD     <= `CSR_NONE;
            CSR_WA       <= '0;
            CSR_WD       <= '0;
            RESP_VALID   <= 1'b0;
            RESP_RD      <= '0;
            RESP_WE      <= 1'b0;
            RESP_DATA    <= '0;
            RESP_ILLEGAL <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        csr_q      <= REQ_CSR;
                        rd_q       <= REQ_RD;
                        operand_q  <= operand;
                        cmd_q      <= dec_cmd;
                        do_write_q <= dec_do_write;
                        if (dec_illegal) begin
                            state        <= RESP;
                            RESP_VALID   <= 1'b1;
                            RESP_RD      <= REQ_RD;
                            RESP_WE      <= 1'b0;
                            RESP_DATA    <= '0;
                            RESP_ILLEGAL <= 1'b1;
                        end else begin
                            state  <= READ;
                            CSR_RA <= REQ_CSR;
                            // Fast path: the CSR file samples the read before its own update edge.
                            if (FASTPATH && dec_do_write) begin
                                CSR_WCMD <= dec_cmd;
                                CSR_WA   <= REQ_CSR;
                                CSR_WD   <= operand;
                            end
                        end
                    end
                end
                READ: begin
                    CSR_RA   <= '0;
                    old_q    <= CSR_RD;
                    CSR_WCMD <= `CSR_NONE;
                    CSR_WA   <= '0;
                    CSR_WD   <= '0;
                    if (!FASTPATH && do_write_q) begin
                        state    <= WRITE;
                        CSR_WCMD <= cmd_q;
                        CSR_WA   <= csr_q;
                        CSR_WD   <= operand_q;
                    end else begin
                        state        <= RESP;
                        RESP_VALID   <= 1'b1;
                        RESP_RD      <= rd_q;
                        RESP_WE      <= (rd_q != 5'd0);
                        RESP_DATA    <= CSR_RD;
                        RESP_ILLEGAL <= 1'b0;
                    end
                end
                WRITE: begin
                    CSR_WCMD     <= `CSR_NONE;
                    CSR_WA       <= '0;
                    CSR_WD       <= '0;
                    state        <= RESP;
                    RESP_VALID   <= 1'b1;
                    RESP_RD      <= rd_q;
                    RESP_WE      <= (rd_q != 5'd0);
                    RESP_DATA    <= old_q;
                    RESP_ILLEGAL <= 1'b0;
                end
                RESP: begin
                    if (RESP_READY) begin
                        state        <= IDLE;
                        RESP_VALID   <= 1'b0;
                        RESP_RD      <= '0;
                        RESP_WE      <= 1'b0;
                        RESP_DATA    <= '0;
                        RESP_ILLEGAL <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leve1_csr_exec.sv
// Randomised bench for leve1_csr_exec with a behavioural CSR-file model and scoreboard.
`ifndef CSR_NONE
`define CSR_NONE  2'd0
`define CSR_WRITE 2'd1
`define CSR_SET   2'd2
`define CSR_CLEAR 2'd3
`endif
`ifndef MODE_U
`define MODE_U 2'd0
`define MODE_S 2'd1
`define MODE_M 2'd3
`endif

module tb_leve1_csr_exec;

`ifdef LEVE1_CSR_EXEC_FASTPATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [2:0]  REQ_FUNCT3 = '0;
    logic [11:0] REQ_CSR = '0;
    logic [4:0]  REQ_RS1 = '0;
    logic [63:0] REQ_RS1_VAL = '0;
    logic [4:0]  REQ_RD = '0;
    logic [1:0]  REQ_MODE = '0;
    logic [11:0] CSR_RA;
    logic [63:0] CSR_RD;
    logic [1:0]  CSR_WCMD;
    logic [11:0] CSR_WA;
    logic [63:0] CSR_WD;
    logic        RESP_VALID;
    logic        RESP_READY = 1'b0;
    logic [4:0]  RESP_RD;
    logic        RESP_WE;
    logic [63:0] RESP_DATA;
    logic        RESP_ILLEGAL;
    logic        RETIRE;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    leve1_csr_exec #(.XLEN(64), .MODE_CHECK(1'b1)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_FUNCT3(REQ_FUNCT3),
        .REQ_CSR(REQ_CSR), .REQ_RS1(REQ_RS1), .REQ_RS1_VAL(REQ_RS1_VAL),
        .REQ_RD(REQ_RD), .REQ_MODE(REQ_MODE),
        .CSR_RA(CSR_RA), .CSR_RD(CSR_RD), .CSR_WCMD(CSR_WCMD), .CSR_WA(CSR_WA), .CSR_WD(CSR_WD),
        .RESP_VALID(RESP_VALID), .RESP_READY(RESP_READY), .RESP_RD(RESP_RD),
        .RESP_WE(RESP_WE), .RESP_DATA(RESP_DATA), .RESP_ILLEGAL(RESP_ILLEGAL),
        .RETIRE(RETIRE)
    );

    // CSR file stand-in: combinational read, command applied at the clock edge.
    logic [63:0] csr_mem [4096];
    logic [63:0] ref_mem [4096];
    logic        pl_init = 1'b0;
    logic        pl_en   = 1'b0;
    logic [11:0] pl_addr = '0;
    logic [63:0] pl_data = '0;

    function automatic logic [63:0] init_val(input int i);
        return {32'(i) * 32'h9E37_79B9, 32'(i) ^ 32'h5A5A_0000};
    endfunction

    assign CSR_RD = csr_mem[CSR_RA];

    always @(posedge CLK) begin
        if (pl_init) begin
            for (int i = 0; i < 4096; i++) csr_mem[i] <= init_val(i);
        end else if (pl_en) begin
            csr_mem[pl_addr] <= pl_data;
        end else begin
            case (CSR_WCMD)
                `CSR_WRITE: csr_mem[CSR_WA] <= CSR_WD;
                `CSR_SET:   csr_mem[CSR_WA] <= csr_mem[CSR_WA] | CSR_WD;
                `CSR_CLEAR: csr_mem[CSR_WA] <= csr_mem[CSR_WA] & ~CSR_WD;
                default: ;
            endcase
        end
    end

    int          wcmd_cnt = 0;
    logic [1:0]  last_cmd;
    logic [11:0] last_wa;
    logic [63:0] last_wd;
    time         wcmd_time;
    int          retire_cnt = 0;

    always @(negedge CLK) begin
        if (CSR_WCMD != `CSR_NONE) begin
            wcmd_cnt++;
            last_cmd  = CSR_WCMD;
            last_wa   = CSR_WA;
            last_wd   = CSR_WD;
            wcmd_time = $time;
        end
    end

    always @(negedge CLK) begin
        #2;
        if (RETIRE) retire_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        else n_pass++;
    endtask

    task automatic set_csr(input logic [11:0] addr, input logic [63:0] val);
        @(negedge CLK);
        pl_en = 1'b1; pl_addr = addr; pl_data = val;
        ref_mem[addr] = val;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] csr, input logic [4:0] rs1,
                           input logic [63:0] rs1_val, input logic [4:0] rd, input logic [1:0] mode,
                           input int hold);
        logic        dw, ill, ex_we;
        logic [63:0] op, oldv, newv, ex_data;
        logic [1:0]  ex_cmd;
        int          ex_lat, k, lat, w0, r0, wcyc;
        time         t_acc;

        // Reference: architectural Zicsr semantics on the model CSR array.
        oldv = ref_mem[csr];
        dw   = (f3 == 3'd1) || (f3 == 3'd5) || (rs1 != 5'd0);
        ill  = (f3 == 3'd0) || (f3 == 3'd4)
            || (dw && csr[11:10] == 2'b11)
            || (csr[9:8] > mode);
        op   = (f3 >= 3'd4) ? 64'(rs1) : rs1_val;
        case (f3 % 4)
            1:       begin newv = op;          ex_cmd = `CSR_WRITE; end
            2:       begin newv = oldv | op;   ex_cmd = `CSR_SET;   end
            default: begin newv = oldv & ~op;  ex_cmd = `CSR_CLEAR; end
        endcase
        if (!ill && dw) ref_mem[csr] = newv;
        ex_we   = !ill && (rd != 5'd0);
        ex_data = ill ? 64'd0 : oldv;
        ex_lat  = ill ? 1 : ((dw && !FAST) ? 3 : 2);

        @(negedge CLK);
        k = 0;
        while (!REQ_READY && k < 20) begin @(negedge CLK); k++; end
        chk("req_ready_idle", 64'(REQ_READY), 64'd1);
        REQ_VALID = 1'b1; REQ_FUNCT3 = f3; REQ_CSR = csr; REQ_RS1 = rs1;
        REQ_RS1_VAL = rs1_val; REQ_RD = rd; REQ_MODE = mode;
        w0 = wcmd_cnt; r0 = retire_cnt;
        @(posedge CLK);
        t_acc = $time;
        #1 REQ_VALID = 1'b0;
        lat = 0;
        do begin @(negedge CLK); lat++; end while (!RESP_VALID && lat < 20);
        chk("latency", 64'(lat), 64'(ex_lat));
        repeat (hold) begin
            chk("hold_rd", 64'(RESP_RD), 64'(rd));
            chk("hold_data", RESP_DATA, ex_data);
            chk("hold_valid", 64'(RESP_VALID), 64'd1);
            chk("hold_req_ready", 64'(REQ_READY), 64'd0);
            chk("hold_retire", 64'(RETIRE), 64'd0);
            @(negedge CLK);
        end
        RESP_READY = 1'b1;
        #1;
        chk("resp_rd", 64'(RESP_RD), 64'(rd));
        chk("resp_we", 64'(RESP_WE), 64'(ex_we));
        chk("resp_data", RESP_DATA, ex_data);
        chk("resp_illegal", 64'(RESP_ILLEGAL), 64'(ill));
        chk("retire", 64'(RETIRE), 64'(!ill));
        @(posedge CLK);
        #1 RESP_READY = 1'b0;
        @(negedge CLK);
        chk("resp_valid_clr", 64'(RESP_VALID), 64'd0);
        chk("wcmd_count", 64'(wcmd_cnt - w0), 64'(!ill && dw));
        if (!ill && dw) begin
            wcyc = int'((wcmd_time - t_acc + 5) / 10);
            chk("wcmd", 64'(last_cmd), 64'(ex_cmd));
            chk("wa", 64'(last_wa), 64'(csr));
            chk("wd", last_wd, op);
            chk("wcmd_cycle", 64'(wcyc), FAST ? 64'd1 : 64'd2);
        end
        chk("csr_value", csr_mem[csr], ref_mem[csr]);
        chk("retire_count", 64'(retire_cnt - r0), 64'(!ill));
    endtask

    task automatic reset_mid_read();
        int w0;
        set_csr(12'h340, 64'h5555);
        @(negedge CLK);
        REQ_VALID = 1'b1; REQ_FUNCT3 = 3'b001; REQ_CSR = 12'h340; REQ_RS1 = 5'd3;
        REQ_RS1_VAL = 64'hBEEF; REQ_RD = 5'd2; REQ_MODE = `MODE_M;
        w0 = wcmd_cnt;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        chk("rst_in_read_ra", 64'(CSR_RA), 64'h340);
        RST = 1'b1;
        #1;
        chk("rst_req_ready", 64'(REQ_READY), 64'd0);
        chk("rst_wcmd", 64'(CSR_WCMD), 64'(`CSR_NONE));
        chk("rst_ra", 64'(CSR_RA), 64'd0);
        chk("rst_wd", CSR_WD, 64'd0);
        chk("rst_resp_valid", 64'(RESP_VALID), 64'd0);
        chk("rst_retire", 64'(RETIRE), 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        #1 chk("rst_release_ready", 64'(REQ_READY), 64'd1);
        repeat (3) @(negedge CLK);
        chk("rst_no_write", 64'(wcmd_cnt - w0), 64'd0);
        chk("rst_csr_kept", csr_mem[12'h340], 64'h5555);
        chk("rst_resp_idle", 64'(RESP_VALID), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pool [8];
        logic [1:0]  modes [3];
        logic [11:0] a;
        logic [4:0]  r1;
        pool = '{12'h340, 12'hC00, 12'hC01, 12'h300, 12'h100, 12'h7C0, 12'hF11, 12'h200};
        modes = '{`MODE_U, `MODE_S, `MODE_M};
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(i);
        pl_init = 1'b1;
        repeat (2) @(posedge CLK);
        #1 pl_init = 1'b0;
        chk("reset_req_ready", 64'(REQ_READY), 64'd0);
        chk("reset_resp_valid", 64'(RESP_VALID), 64'd0);
        chk("reset_wcmd", 64'(CSR_WCMD), 64'(`CSR_NONE));
        chk("reset_ra", 64'(CSR_RA), 64'd0);
        chk("reset_retire", 64'(RETIRE), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1 chk("reset_release_ready", 64'(REQ_READY), 64'd1);

        set_csr(12'h340, 64'h1234);
        run_txn(3'b001, 12'h340, 5'd7, 64'hDEAD, 5'd5, `MODE_M, 0);
        run_txn(3'b010, 12'hC00, 5'd0, 64'hFFFF, 5'd10, `MODE_U, 1);
        run_txn(3'b101, 12'hC01, 5'd3, 64'd0, 5'd4, `MODE_M, 0);
        run_txn(3'b011, 12'h300, 5'd9, 64'h2, 5'd6, `MODE_S, 0);
        set_csr(12'h300, 64'h0A);
        run_txn(3'b111, 12'h300, 5'd8, 64'd0, 5'd6, `MODE_M, 0);
        run_txn(3'b001, 12'h340, 5'd1, 64'hCAFE_F00D, 5'd3, `MODE_M, 5);
        run_txn(3'b000, 12'h340, 5'd1, 64'h1, 5'd3, `MODE_M, 0);
        run_txn(3'b100, 12'h340, 5'd1, 64'h1, 5'd3, `MODE_M, 0);
        run_txn(3'b110, 12'h340, 5'd0, 64'h1, 5'd0, `MODE_M, 0);
        reset_mid_read();

        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 7)];
            r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            run_txn(3'($urandom), a, r1, {$urandom, $urandom}, 5'($urandom),
                    modes[$urandom_range(0, 2)], $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
